axis_upsizer: RTL and testbench

Parametrised single-clock AXI-Stream width upsizer: packs RATIO narrow input beats of IN_BYTES each into one output word of IN_BYTES*RATIO bytes.
- Next generation of the fixed 8-to-32 packer in the UDP datapath. Adds input tkeep, full tready backpressure on both sides, selectable lane order and defined partial-word flush on tlast.
- Sits between byte-wide MAC/UDP stages and wider buffering or processing stages.
- Single clock only. CDC stays in a separate async FIFO.

---
 rtl/axis_width_pkg.sv | 38 +++
 rtl/axis_upsizer.sv | 145 ++++++++++++++
 tb/tb_axis_upsizer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_width_pkg.sv
// rtl/axis_width_pkg.sv - shared width/lane helpers for AXI-Stream width converters
//
// Purpose: constant-evaluable helpers used by the upsizer (and the future
// downsizer) to size counters and buses and to map beat index to output lane.
// Ports: none (package).
package axis_width_pkg;

  localparam int BYTE_W = 8;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Lane that beat k of a word occupies inside the wide word.
  function automatic int lane_index(input int k, input int ratio, input bit big_endian);
    return big_endian ? (ratio - 1 - k) : k;
  endfunction

  // Data bus width in bits for a given byte count.
  function automatic int data_w(input int bytes);
    return bytes * BYTE_W;
  endfunction

  // Keep bus width for a given data width in bits.
  function automatic int keep_w(input int data_bits);
    return data_bits / BYTE_W;
  endfunction

endpackage

// File: rtl/axis_upsizer.sv
// rtl/axis_upsizer.sv - AXI-Stream width upsizer packing RATIO narrow beats into one wide word
//
// Purpose: accumulates RATIO input beats of IN_BYTES each into an output word
// of IN_BYTES*RATIO bytes; tlast flushes a partial word with unfilled lanes
// carrying data 0 / keep 0. One completed word can wait in the accumulator
// while the output register is stalled.
// Ports:
//   clk, reset_n                    single clock, asynchronous active-low reset
//   s_axis_tdata/tkeep/tvalid/tlast narrow input stream
//   s_axis_tready                   input ready (flop-driven, no path from m_axis_tready)
//   m_axis_tdata/tkeep/tvalid/tlast wide output stream (registered)
//   m_axis_tready                   output ready
module axis_upsizer
  import axis_width_pkg::*;
#(
  parameter int IN_BYTES   = 1,
  parameter int RATIO      = 4,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [8*IN_BYTES-1:0]           s_axis_tdata,
  input  logic [IN_BYTES-1:0]             s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [8*IN_BYTES*RATIO-1:0]     m_axis_tdata,
  output logic [IN_BYTES*RATIO-1:0]       m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
);

  localparam int OUT_BYTES = IN_BYTES * RATIO;
  localparam int CNT_W     = clog2(RATIO);
  localparam int IN_W      = data_w(IN_BYTES);
  localparam int OUT_W     = data_w(OUT_BYTES);
  localparam int OUT_KW    = keep_w(OUT_W);

  logic                 r_rst_done;
  logic                 r_pending;
  logic [CNT_W-1:0]     r_acc_cnt;
  logic [OUT_W-1:0]     r_acc_data;
  logic [OUT_KW-1:0]    r_acc_keep;
  logic                 r_acc_last;

  logic [OUT_W-1:0]     r_m_data;
  logic [OUT_KW-1:0]    r_m_keep;
  logic                 r_m_valid;
  logic                 r_m_last;

  logic                 w_accept;
  logic                 w_complete;
  logic                 w_out_free;
  int                   w_lane;
  logic [OUT_W-1:0]     w_merged_data;
  logic [OUT_KW-1:0]    w_merged_keep;

  // Both terms are flops, so input ready never depends on m_axis_tready
  // combinationally; rst_done holds ready low until the first edge after reset.
  assign s_axis_tready = r_rst_done & ~r_pending;

  assign w_accept   = s_axis_tvalid & s_axis_tready;
  assign w_complete = (r_acc_cnt == CNT_W'(RATIO - 1)) | s_axis_tlast;
  assign w_out_free = ~r_m_valid | m_axis_tready;

  // Accumulator contents with the incoming beat written into its lane.
  always_comb begin
    w_lane        = lane_index(int'(r_acc_cnt), RATIO, BIG_ENDIAN);
    w_merged_data = r_acc_data;
    w_merged_keep = r_acc_keep;
    for (int l = 0; l < RATIO; l++) begin
      if (w_lane == l) begin
        w_merged_data[l*IN_W +: IN_W]         = s_axis_tdata;
        w_merged_keep[l*IN_BYTES +: IN_BYTES] = s_axis_tkeep;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_done <= 1'b0;
      r_pending  <= 1'b0;
      r_acc_cnt  <= '0;
      r_acc_data <= '0;
      r_acc_keep <= '0;
      r_acc_last <= 1'b0;
      r_m_data   <= '0;
      r_m_keep   <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;

      // Handshake drops valid; a load below overrides it in the same cycle.
      if (r_m_valid && m_axis_tready) begin
        r_m_valid <= 1'b0;
      end

      if (r_pending) begin
        // Pending implies the output register is valid, so tready alone
        // means the held word can move out this cycle.
        if (m_axis_tready) begin
          r_m_valid  <= 1'b1;
          r_m_data   <= r_acc_data;
          r_m_keep   <= r_acc_keep;
          r_m_last   <= r_acc_last;
          r_acc_cnt  <= '0;
          r_acc_data <= '0;
          r_acc_keep <= '0;
          r_acc_last <= 1'b0;
          r_pending  <= 1'b0;
        end
      end else if (w_accept) begin
        if (w_complete) begin
          if (w_out_free) begin
            r_m_valid  <= 1'b1;
            r_m_data   <= w_merged_data;
            r_m_keep   <= w_merged_keep;
            r_m_last   <= s_axis_tlast;
            r_acc_cnt  <= '0;
            r_acc_data <= '0;
            r_acc_keep <= '0;
            r_acc_last <= 1'b0;
          end else begin
            r_acc_data <= w_merged_data;
            r_acc_keep <= w_merged_keep;
            r_acc_last <= s_axis_tlast;
            r_pending  <= 1'b1;
          end
        end else begin
          r_acc_data <= w_merged_data;
          r_acc_keep <= w_merged_keep;
          r_acc_cnt  <= r_acc_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign m_axis_tdata  = r_m_data;
  assign m_axis_tkeep  = r_m_keep;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tlast  = r_m_last;

endmodule

// File: tb/tb_axis_upsizer.sv
// tb/tb_axis_upsizer.sv - directed and soak bench for axis_upsizer
//
// Purpose: drives two instances (1B x4 big-endian, 2B x2 little-endian) with
// hand-computed vectors and a random soak against a packing model.
// Ports: none (top-level bench).
module tb_axis_upsizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  a_tdata = '0;
  logic [0:0]  a_tkeep = '0;
  logic        a_tvalid = 1'b0;
  logic        a_tlast = 1'b0;
  logic        a_sready;
  logic [31:0] a_mdata;
  logic [3:0]  a_mkeep;
  logic        a_mvalid;
  logic        a_mlast;
  logic        a_mready = 1'b1;

  logic [15:0] b_tdata = '0;
  logic [1:0]  b_tkeep = '0;
  logic        b_tvalid = 1'b0;
  logic        b_tlast = 1'b0;
  logic        b_sready;
  logic [31:0] b_mdata;
  logic [3:0]  b_mkeep;
  logic        b_mvalid;
  logic        b_mlast;

  int n_checks = 0;
  int n_errors = 0;
  int n_unstable = 0;

  logic [36:0] qa[$];
  logic [36:0] qb[$];
  logic [36:0] exq[$];

  bit          soak_done = 1'b0;
  logic        prev_hold = 1'b0;
  logic [36:0] prev_word = '0;

  axis_upsizer #(.IN_BYTES(1), .RATIO(4), .BIG_ENDIAN(1'b1)) dut_a (
    .clk(clk), .reset_n(rst_n),
    .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tvalid(a_tvalid),
    .s_axis_tlast(a_tlast), .s_axis_tready(a_sready),
    .m_axis_tdata(a_mdata), .m_axis_tkeep(a_mkeep), .m_axis_tvalid(a_mvalid),
    .m_axis_tlast(a_mlast), .m_axis_tready(a_mready)
  );

  axis_upsizer #(.IN_BYTES(2), .RATIO(2), .BIG_ENDIAN(1'b0)) dut_b (
    .clk(clk), .reset_n(rst_n),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
    .s_axis_tlast(b_tlast), .s_axis_tready(b_sready),
    .m_axis_tdata(b_mdata), .m_axis_tkeep(b_mkeep), .m_axis_tvalid(b_mvalid),
    .m_axis_tlast(b_mlast), .m_axis_tready(1'b1)
  );

  always #5 clk = ~clk;

  // Output monitors: a transfer happens at the next rising edge when
  // valid & ready are both high at the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_mvalid && a_mready) qa.push_back({a_mlast, a_mkeep, a_mdata});
      if (b_mvalid) qb.push_back({b_mlast, b_mkeep, b_mdata});
      if (prev_hold && ({a_mlast, a_mkeep, a_mdata} !== prev_word || !a_mvalid))
        n_unstable++;
      prev_hold = a_mvalid && !a_mready;
      prev_word = {a_mlast, a_mkeep, a_mdata};
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Call at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send_a(input logic [7:0] d, input logic k, input logic l);
    int n;
    n = 0;
    a_tdata = d; a_tkeep = k; a_tlast = l; a_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (a_sready) break;
      n++;
      if (n > 1000) begin
        check("send_a_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1 a_tvalid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d, input logic [1:0] k, input logic l);
    int n;
    n = 0;
    b_tdata = d; b_tkeep = k; b_tlast = l; b_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (b_sready) break;
      n++;
      if (n > 1000) begin
        check("send_b_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1 b_tvalid = 1'b0;
  endtask

  task automatic expect_a(input string tag, input logic [31:0] ed, input logic [3:0] ek, input logic el);
    logic [36:0] w;
    check({tag, "_present"}, 64'(qa.size() > 0), 1);
    if (qa.size() > 0) begin
      w = qa.pop_front();
      check({tag, "_data"}, 64'(w[31:0] & kmask(w[35:32])), 64'(ed & kmask(ek)));
      check({tag, "_keep"}, 64'(w[35:32]), 64'(ek));
      check({tag, "_last"}, 64'(w[36]), 64'(el));
    end
  endtask

  initial begin
    logic [7:0]  d;
    logic        k;
    logic        l;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    int          m_cnt;
    logic [36:0] w;

    // Reset state
    #12;
    check("rst_mvalid", a_mvalid, 0);
    check("rst_mdata", a_mdata, 0);
    check("rst_mkeep", a_mkeep, 0);
    check("rst_mlast", a_mlast, 0);
    check("rst_sready", a_sready, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rel_sready_low", a_sready, 0);
    @(negedge clk);
    check("rel_sready_high", a_sready, 1);
    @(posedge clk); #1;

    // Full word, one-cycle latency
    send_a(8'h11, 1, 0); send_a(8'h22, 1, 0); send_a(8'h33, 1, 0); send_a(8'h44, 1, 1);
    @(negedge clk);
    check("t1_valid", a_mvalid, 1);
    check("t1_data", a_mdata, 32'h11223344);
    check("t1_keep", a_mkeep, 4'b1111);
    check("t1_last", a_mlast, 1);
    @(negedge clk);
    check("t1_valid_drop", a_mvalid, 0);
    qa.delete();
    @(posedge clk); #1;

    // Short packet then 5-byte packet
    send_a(8'hAA, 1, 0); send_a(8'hBB, 1, 0); send_a(8'hCC, 1, 1);
    for (int i = 1; i <= 5; i++) send_a(8'(i), 1, (i == 5));
    repeat (3) @(posedge clk); #1;
    expect_a("t2_w0", 32'hAABBCC00, 4'b1110, 1);
    expect_a("t2_w1", 32'h01020304, 4'b1111, 0);
    expect_a("t2_w2", 32'h05000000, 4'b1000, 1);

    // Little-endian 2-byte lanes, partial keep
    send_b(16'h1234, 2'b11, 0); send_b(16'h5678, 2'b01, 1);
    @(negedge clk);
    check("t3_valid", b_mvalid, 1);
    check("t3_data", b_mdata & kmask(b_mkeep), 32'h00781234);
    check("t3_keep", b_mkeep, 4'b0111);
    check("t3_last", b_mlast, 1);
    @(posedge clk); #1;

    // Backpressure: one word held, second pending
    a_mready = 1'b0;
    for (int i = 0; i < 8; i++) send_a(8'h10 + 8'(i), 1, 0);
    @(negedge clk);
    check("t4_sready_pend", a_sready, 0);
    check("t4_hold_valid", a_mvalid, 1);
    check("t4_hold_data", a_mdata, 32'h10111213);
    repeat (3) @(negedge clk);
    check("t4_hold_data2", a_mdata, 32'h10111213);
    check("t4_sready_pend2", a_sready, 0);
    qa.delete();
    @(posedge clk); #1 a_mready = 1'b1;
    @(negedge clk);
    check("t4_sready_before", a_sready, 0);
    @(negedge clk);
    check("t4_sready_after", a_sready, 1);
    check("t4_w1_valid", a_mvalid, 1);
    check("t4_w1_data", a_mdata, 32'h14151617);
    repeat (2) @(posedge clk); #1;
    check("t4_count", qa.size(), 2);
    expect_a("t4_w0", 32'h10111213, 4'b1111, 0);
    expect_a("t4_w1", 32'h14151617, 4'b1111, 0);

    // Null tlast on empty accumulator
    send_a(8'h99, 0, 1);
    repeat (3) @(posedge clk); #1;
    expect_a("t5_null", 32'h0, 4'b0000, 1);

    // Reset in the middle of a word
    send_a(8'hA1, 1, 0); send_a(8'hA2, 1, 0);
    #3 rst_n = 1'b0;
    #1;
    check("t6_mdata", a_mdata, 0);
    check("t6_mlast", a_mlast, 0);
    check("t6_mvalid", a_mvalid, 0);
    check("t6_sready", a_sready, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("t6_rel_sready0", a_sready, 0);
    @(negedge clk);
    check("t6_edge0_sready", a_sready, 0);
    @(negedge clk);
    check("t6_edge1_sready", a_sready, 1);
    qa.delete();
    @(posedge clk); #1;
    send_a(8'hB1, 1, 0); send_a(8'hB2, 1, 0); send_a(8'hB3, 1, 0); send_a(8'hB4, 1, 0);
    repeat (3) @(posedge clk); #1;
    expect_a("t6_clean", 32'hB1B2B3B4, 4'b1111, 0);

    // Random soak against a packing model
    qa.delete();
    m_data = '0; m_keep = '0; m_cnt = 0;
    fork
      begin
        for (int b = 0; b < 10000; b++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          d = 8'($urandom_range(0, 255));
          k = 1'($urandom_range(0, 1));
          l = ($urandom_range(0, 7) == 0);
          send_a(d, k, l);
          m_data[(3 - m_cnt)*8 +: 8] = d;
          m_keep[3 - m_cnt] = k;
          if (m_cnt == 3 || l) begin
            exq.push_back({l, m_keep, m_data});
            m_data = '0; m_keep = '0; m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
        soak_done = 1'b1;
      end
      begin
        while (!soak_done) begin
          @(posedge clk);
          #1 a_mready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    a_mready = 1'b1;
    repeat (30) @(posedge clk); #1;
    check("soak_count", qa.size(), exq.size());
    while (exq.size() > 0 && qa.size() > 0) begin
      w = exq.pop_front();
      expect_a("soak", w[31:0], w[35:32], w[36]);
    end
    check("soak_stable", n_unstable, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
